// File: rtl/test_end_monitor.sv
// test_end_monitor: end-of-test verdict monitor snooping the register-file write port.
// Declares PASS when REG_A and REG_B both last received PASS_VALUE, FAIL when
// FAIL_VALUE is written to REG_A, and TIMEOUT after TIMEOUT_CYCLES RUN cycles.
// Optional feature macro: TEST_END_MONITOR_TIMEOUT_EN (timeout transition and state).
module test_end_monitor #(
    parameter int unsigned       WORD_W         = 32,
    parameter int unsigned       REG_A          = 30,
    parameter int unsigned       REG_B          = 31,
    parameter logic [WORD_W-1:0] PASS_VALUE     = 32'hBEEFBEEF,
    parameter logic [WORD_W-1:0] FAIL_VALUE     = 32'hDEADDEAD,
    parameter int unsigned       TIMEOUT_CYCLES = 200,
    parameter int unsigned       CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              enable,
    input  logic              clear,
    input  logic              rf_wen,
    input  logic [4:0]        rf_waddr,
    input  logic [WORD_W-1:0] rf_wdata,
    output logic [2:0]        state,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StRun     = 3'd1,
        StPass    = 3'd2,
        StFail    = 3'd3,
        StTimeout = 3'd4
    } state_e;

    localparam logic [4:0]       RegAIdx = 5'(REG_A);
    localparam logic [4:0]       RegBIdx = 5'(REG_B);
    localparam logic [CNT_W-1:0] CntMax  = '1;
`ifdef TEST_END_MONITOR_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    state_e           state_q, state_d;
    logic             a_ok_q, a_ok_d;
    logic             b_ok_q, b_ok_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic wr_a, wr_b, wr_fail;

    // Qualify writes to the watched registers; x0 writes never count.
    always_comb begin
        wr_a    = rf_wen && (rf_waddr != 5'd0) && (rf_waddr == RegAIdx);
        wr_b    = rf_wen && (rf_waddr != 5'd0) && (rf_waddr == RegBIdx);
        wr_fail = wr_a && (rf_wdata == FAIL_VALUE);
    end

    // Next-state, flag and counter logic; clear overrides everything.
    always_comb begin
        state_d = state_q;
        a_ok_d  = a_ok_q;
        b_ok_d  = b_ok_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                a_ok_d = 1'b0;
                b_ok_d = 1'b0;
                cnt_d  = '0;
                if (enable) state_d = StRun;
            end
            StRun: begin
                if (wr_a) a_ok_d = (rf_wdata == PASS_VALUE);
                if (wr_b) b_ok_d = (rf_wdata == PASS_VALUE);
                cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);
                // The pass check uses the updated flags so the completing write counts.
                if (wr_fail) begin
                    state_d = StFail;
                end else if (a_ok_d && b_ok_d) begin
                    state_d = StPass;
`ifdef TEST_END_MONITOR_TIMEOUT_EN
                end else if (cnt_q == TimeoutLast) begin
                    state_d = StTimeout;
`endif
                end
            end
            StPass, StFail, StTimeout: state_d = state_q;
            default: state_d = StIdle;
        endcase
        if (clear) begin
            state_d = StIdle;
            a_ok_d  = 1'b0;
            b_ok_d  = 1'b0;
            cnt_d   = '0;
        end
    end

    // State, flag and counter registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= StIdle;
            a_ok_q  <= 1'b0;
            b_ok_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_ok_q  <= a_ok_d;
            b_ok_q  <= b_ok_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode the registered state only; no path from rf_* inputs.
    always_comb begin
        state       = state_q;
        done        = (state_q == StPass) || (state_q == StFail) || (state_q == StTimeout);
        pass        = (state_q == StPass);
        fail        = (state_q == StFail) || (state_q == StTimeout);
`ifdef TEST_END_MONITOR_TIMEOUT_EN
        timeout     = (state_q == StTimeout);
`else
        timeout     = 1'b0;
`endif
        cycle_count = cnt_q;
    end

endmodule

// File: tb/tb_test_end_monitor.sv
// Bench for test_end_monitor: directed scenarios plus random traffic, checked every
// cycle against a behavioural model that remembers the last values written to the
// watched registers and an unbounded RUN-cycle count.
module tb_test_end_monitor;

    localparam int unsigned TO     = 200;
    localparam int unsigned CNT_W  = $clog2(TO + 1);
    localparam int unsigned CNTMAX = (1 << CNT_W) - 1;
    localparam logic [31:0] PASSV  = 32'hBEEFBEEF;
    localparam logic [31:0] FAILV  = 32'hDEADDEAD;
`ifdef TEST_END_MONITOR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             nrst, enable, clear, rf_wen;
    logic [4:0]       rf_waddr;
    logic [31:0]      rf_wdata;
    logic [2:0]       state;
    logic             done, pass, fail, timeout;
    logic [CNT_W-1:0] cycle_count;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // Behavioural model: verdict state 0..4, last watched-register values, RUN cycles.
    int          m_state;
    bit          m_has_a, m_has_b;
    logic [31:0] m_last_a, m_last_b;
    int          m_runs;

    test_end_monitor #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .enable     (enable),
        .clear      (clear),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .state      (state),
        .done       (done),
        .pass       (pass),
        .fail       (fail),
        .timeout    (timeout),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_has_a = 1'b0;
        m_has_b = 1'b0;
        m_runs  = 0;
    endtask

    // One clock edge of the model, using the inputs as they stood at that edge.
    task automatic model_step();
        bit wa, wb;
        if (!nrst) begin
            model_reset();
        end else if (clear) begin
            model_reset();
        end else if (m_state == 0) begin
            if (enable) begin
                model_reset();
                m_state = 1;
            end
        end else if (m_state == 1) begin
            wa = rf_wen && rf_waddr != 0 && rf_waddr == 5'd30;
            wb = rf_wen && rf_waddr != 0 && rf_waddr == 5'd31;
            if (wa) begin m_has_a = 1'b1; m_last_a = rf_wdata; end
            if (wb) begin m_has_b = 1'b1; m_last_b = rf_wdata; end
            m_runs++;
            if (wa && rf_wdata == FAILV)
                m_state = 3;
            else if (m_has_a && m_has_b && m_last_a == PASSV && m_last_b == PASSV)
                m_state = 2;
            else if (TO_EN && m_runs == TO)
                m_state = 4;
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("state", state, m_state);
            check("done", done, m_state >= 2);
            check("pass", pass, m_state == 2);
            check("fail", fail, m_state == 3 || m_state == 4);
            check("timeout", timeout, m_state == 4);
            check("cycle_count", cycle_count, (m_runs > CNTMAX) ? CNTMAX : m_runs);
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        rf_wen   = 1'b1;
        rf_waddr = a;
        rf_wdata = d;
        cyc();
        rf_wen   = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = '0;
    endtask

    task automatic do_enable();
        enable = 1'b1;
        cyc();
        enable = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    initial begin
        nrst = 1'b0; enable = 1'b0; clear = 1'b0;
        rf_wen = 1'b0; rf_waddr = '0; rf_wdata = '0;
        model_reset();
        #12;
        check("reset_state", state, 0);
        check("reset_done", done, 0);
        check("reset_cnt", cycle_count, 0);
        @(negedge clk);
        #1;
        nrst = 1'b1;
        chk_on = 1'b1;

        // Pair completed on RUN cycles 5 and 9; enable-cycle write is ignored.
        rf_wen = 1'b1; rf_waddr = 5'd30; rf_wdata = PASSV;
        do_enable();
        rf_wen = 1'b0; rf_waddr = '0; rf_wdata = '0;
        idle(5);
        wr(5'd30, PASSV);
        idle(3);
        check("s1_not_yet", pass, 0);
        wr(5'd31, PASSV);
        check("s1_pass", pass, 1);
        check("s1_done", done, 1);
        check("s1_cnt", cycle_count, 10);
        idle(20);
        check("s1_sticky", pass, 1);
        check("s1_cnt_frozen", cycle_count, 10);

        // A later non-matching write clears the flag.
        do_clear();
        check("clear_idle", state, 0);
        do_enable();
        wr(5'd30, PASSV);
        wr(5'd30, 32'h1);
        wr(5'd31, PASSV);
        check("s2_no_pass", state, 1);
        wr(5'd30, PASSV);
        check("s2_pass", state, 2);

        // Failure signature at RUN cycle 3.
        do_clear();
        do_enable();
        idle(3);
        wr(5'd30, FAILV);
        check("s3_state", state, 3);
        check("s3_fail", fail, 1);
        check("s3_pass", pass, 0);

        // No signatures: timeout, or (without the feature) free-running saturated count.
        do_clear();
        do_enable();
        if (TO_EN) begin
            idle(200);
            check("s4_timeout", timeout, 1);
            check("s4_fail", fail, 1);
            check("s4_cnt", cycle_count, 200);
        end else begin
            idle(300);
            check("s4_run", state, 1);
            check("s4_cnt_sat", cycle_count, 255);
        end

        // Pair completed on RUN cycle 199 wins over the timeout.
        do_clear();
        do_enable();
        wr(5'd30, PASSV);
        idle(198);
        wr(5'd31, PASSV);
        check("s5_pass", state, 2);
        check("s5_cnt", cycle_count, 200);

        // Asynchronous reset mid-RUN wipes the x30 flag.
        do_clear();
        do_enable();
        wr(5'd30, PASSV);
        idle(2);
        nrst = 1'b0;
        model_reset();
        #1;
        check("s6_rst_state", state, 0);
        check("s6_rst_cnt", cycle_count, 0);
        #1;
        nrst = 1'b1;
        idle(1);
        do_enable();
        wr(5'd31, PASSV);
        idle(2);
        check("s6_no_pass", state, 1);
        wr(5'd30, PASSV);
        check("s6_pass", pass, 1);
        do_clear();
        check("s6_clear", state, 0);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(99);
            clear  = (r < 2) || (m_state >= 2 && r < 12);
            enable = ($urandom_range(99) < 30);
            rf_wen = 1'($urandom_range(1));
            case ($urandom_range(3))
                0:       rf_waddr = 5'd0;
                1:       rf_waddr = 5'd30;
                2:       rf_waddr = 5'd31;
                default: rf_waddr = 5'($urandom_range(31));
            endcase
            r = $urandom_range(11);
            if (r < 6)       rf_wdata = PASSV;
            else if (r == 6) rf_wdata = FAILV;
            else             rf_wdata = $urandom;
            cyc();
        end
        clear = 1'b0; enable = 1'b0; rf_wen = 1'b0;
        idle(2);

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
